// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter: round-robin share of the L2 cache port between instruction and data L1 with timeout abort
module l2_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11,
  parameter int BLOCK_SIZE = 32,
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic p0_rd,
  input  logic p1_rd,
  input  logic p0_wr,
  input  logic p1_wr,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] p0_wdata,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] p1_wdata,
  output logic p0_ack,
  output logic p1_ack,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] p0_rdata,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] p1_rdata,
  output logic p0_hit,
  output logic p1_hit,
  output logic p0_err,
  output logic p1_err,
  output logic [ADDR_WIDTH-1:0] l2_addr,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] l2_data_in,
  output logic l2_read,
  output logic l2_write,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] l2_block_data_out,
  input  logic l2_block_valid,
  input  logic l2_ready,
  input  logic l2_hit,
  output logic grant_id,
  output logic busy
);
  localparam int BW = BLOCK_SIZE * DATA_WIDTH;
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RECOVER = 2'd2;
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic rr;
  logic req0, req1, gnt, expire;
  logic [BW-1:0] rsp;
  assign req0 = p0_rd | p0_wr;
  assign req1 = p1_rd | p1_wr;
  // rr names the port that wins a tie; it flips away from each winner
  assign gnt = (req0 & req1) ? rr : req1;
  assign expire = cnt == CW'(TIMEOUT - 1);
  assign rsp = l2_block_valid ? l2_block_data_out : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      rr <= 1'b0;
      grant_id <= 1'b0;
      busy <= 1'b0;
      l2_addr <= '0;
      l2_data_in <= '0;
      l2_read <= 1'b0;
      l2_write <= 1'b0;
      p0_ack <= 1'b0;
      p1_ack <= 1'b0;
      p0_rdata <= '0;
      p1_rdata <= '0;
      p0_hit <= 1'b0;
      p1_hit <= 1'b0;
      p0_err <= 1'b0;
      p1_err <= 1'b0;
    end else begin
      p0_ack <= 1'b0;
      p1_ack <= 1'b0;
      p0_rdata <= '0;
      p1_rdata <= '0;
      p0_hit <= 1'b0;
      p1_hit <= 1'b0;
      p0_err <= 1'b0;
      p1_err <= 1'b0;
      case (state)
        IDLE: if (req0 | req1) begin
          state <= WAIT;
          busy <= 1'b1;
          grant_id <= gnt;
          rr <= ~gnt;
          cnt <= '0;
          l2_addr <= gnt ? p1_addr : p0_addr;
          l2_data_in <= gnt ? p1_wdata : p0_wdata;
          l2_write <= gnt ? p1_wr : p0_wr;
          l2_read <= gnt ? (p1_rd & ~p1_wr) : (p0_rd & ~p0_wr);
        end
        WAIT: if (l2_ready | expire) begin
          state <= RECOVER;
          l2_read <= 1'b0;
          l2_write <= 1'b0;
          p0_ack <= ~grant_id;
          p1_ack <= grant_id;
          p0_rdata <= (~grant_id & l2_ready) ? rsp : '0;
          p1_rdata <= (grant_id & l2_ready) ? rsp : '0;
          p0_hit <= ~grant_id & l2_ready & l2_hit;
          p1_hit <= grant_id & l2_ready & l2_hit;
          p0_err <= ~grant_id & ~l2_ready;
          p1_err <= grant_id & ~l2_ready;
        end else
          cnt <= cnt + 1'b1;
        default: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
endmodule
